readout_sequencer: RTL and testbench

Sequences the per-channel readout through the serial-output mux. On a readout instruction it walks the enabled channels in ascending order. For each channel it drives `select_reg`, waits for the mux to settle, then asserts `clk_enable` for exactly one channel word of shift clocks. It sits between the SPI instruction decode (`inst_readout`, `inst_rst`, `trigger_channel_mask`) and the channel mux/shift-register clock gating.

---
 rtl/psec5_readout_pkg.sv | 15 +
 rtl/next_chan_finder.sv | 24 ++
 rtl/readout_sequencer.sv | 131 +++++++++++++
 tb/tb_readout_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/psec5_readout_pkg.sv
// Shared types and constants for the channel readout sequencer.
package psec5_readout_pkg;

    localparam int unsigned NUM_CHAN = 8;
    localparam int unsigned CHAN_W   = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        SHIFT  = 3'd2,
        NEXT   = 3'd3,
        DONE   = 3'd4
    } rs_state_t;

endpackage

// File: rtl/next_chan_finder.sv
// Combinational search for the lowest enabled channel above (or at) the current index.
module next_chan_finder
    import psec5_readout_pkg::*;
(
    input  logic [NUM_CHAN-1:0] mask,
    input  logic [CHAN_W-1:0]   cur,
    input  logic                incl,
    output logic [CHAN_W-1:0]   next_idx,
    output logic                found
);

    // Descending scan so the lowest qualifying index is the one left standing.
    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        for (int i = NUM_CHAN - 1; i >= 0; i--) begin
            if (mask[i] && ((CHAN_W'(i) > cur) || (incl && (CHAN_W'(i) == cur)))) begin
                found    = 1'b1;
                next_idx = CHAN_W'(i);
            end
        end
    end

endmodule

// File: rtl/readout_sequencer.sv
// Walks enabled channels: select mux, settle, then gate one channel word of shift clocks.
module readout_sequencer
    import psec5_readout_pkg::*;
#(
    parameter int unsigned BITS_PER_CHAN = 56,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_readout,
    input  logic                inst_rst,
    input  logic [NUM_CHAN-1:0] trigger_channel_mask,
    output logic [CHAN_W-1:0]   select_reg,
    output logic                clk_enable,
    output logic                last_bit,
    output logic                busy,
    output logic                done
);

    localparam int unsigned       BIT_W       = $clog2(BITS_PER_CHAN);
    localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(BITS_PER_CHAN - 1);
    localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    rs_state_t             state_q, state_d;
    logic                  start_q, start_d;
    logic [NUM_CHAN-1:0]   mask_q, mask_d;
    logic [CHAN_W-1:0]     sel_q, sel_d;
    logic [3:0]            settle_q, settle_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  clk_en_q, last_q, busy_q, done_q;

    logic [CHAN_W-1:0]     next_idx;
    logic                  found;

    // The first search from IDLE must include channel 0 itself.
    next_chan_finder u_finder (
        .mask     (mask_q),
        .cur      (sel_q & {CHAN_W{state_q != IDLE}}),
        .incl     (state_q == IDLE),
        .next_idx (next_idx),
        .found    (found)
    );

    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        mask_d   = mask_q;
        sel_d    = sel_q;
        settle_d = settle_q;
        bit_d    = bit_q;
        if (inst_rst) begin
            state_d = IDLE;
            start_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // start_q marks the cycle after the mask was latched.
                    if (start_q) begin
                        start_d = 1'b0;
                        if (found) begin
                            sel_d    = next_idx;
                            settle_d = '0;
                            state_d  = SELECT;
                        end else begin
                            state_d = DONE;
                        end
                    end else if (inst_readout) begin
                        mask_d  = trigger_channel_mask;
                        start_d = 1'b1;
                    end
                end
                SELECT: begin
                    if (settle_q == SETTLE_LAST) begin
                        bit_d   = '0;
                        state_d = SHIFT;
                    end else begin
                        settle_d = settle_q + 4'd1;
                    end
                end
                SHIFT: begin
                    if (bit_q == BIT_LAST) state_d = NEXT;
                    else                   bit_d   = bit_q + 1'b1;
                end
                NEXT: begin
                    if (found) begin
                        sel_d    = next_idx;
                        settle_d = '0;
                        state_d  = SELECT;
                    end else begin
                        state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            mask_q   <= '0;
            sel_q    <= '0;
            settle_q <= '0;
            bit_q    <= '0;
            clk_en_q <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            mask_q   <= mask_d;
            sel_q    <= sel_d;
            settle_q <= settle_d;
            bit_q    <= bit_d;
            clk_en_q <= (state_d == SHIFT);
            last_q   <= (state_d == SHIFT) && (bit_d == BIT_LAST);
            busy_q   <= (state_d != IDLE);
            done_q   <= (state_d == DONE);
        end
    end

    assign select_reg = sel_q;
    assign clk_enable = clk_en_q;
    assign last_bit   = last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_readout_sequencer.sv
// Randomised directed bench for readout_sequencer against a channel-list reference model.
module tb_readout_sequencer;

    localparam int unsigned B = 56;
    localparam int unsigned S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inst_readout = 1'b0;
    logic       inst_rst = 1'b0;
    logic [7:0] trigger_channel_mask = 8'h00;
    logic [2:0] select_reg;
    logic       clk_enable;
    logic       last_bit;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    readout_sequencer #(
        .BITS_PER_CHAN (B),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .inst_readout         (inst_readout),
        .inst_rst             (inst_rst),
        .trigger_channel_mask (trigger_channel_mask),
        .select_reg           (select_reg),
        .clk_enable           (clk_enable),
        .last_bit             (last_bit),
        .busy                 (busy),
        .done                 (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_pulse(input logic [7:0] m);
        @(negedge clk);
        trigger_channel_mask = m;
        inst_readout = 1'b1;
        @(negedge clk);
        inst_readout = 1'b0;
    endtask

    // Full readout with the mask scrambled every cycle; optional stray request at overlap_at.
    task automatic do_readout(input logic [7:0] m, input int overlap_at);
        int exp_q[$];
        int seq[$];
        int k, idx, busy_n, ce_n, lb_n, dn_n, first_ce, quiet, viol, bad_run, run;
        logic done_last, prev_ce, prev_lb;
        logic [2:0] prev_sel;
        bit fin;
        for (int i = 0; i < 8; i++) if (m[i]) exp_q.push_back(i);
        k = exp_q.size();
        @(negedge clk);
        trigger_channel_mask = m;
        inst_readout = 1'b1;
        @(negedge clk);
        inst_readout = 1'b0;
        trigger_channel_mask = 8'($urandom);
        chk("latch_cycle_busy", {31'b0, busy}, 0);
        prev_sel = select_reg;
        busy_n = 0; ce_n = 0; lb_n = 0; dn_n = 0; first_ce = -1; quiet = 0;
        viol = 0; bad_run = 0; run = 0; idx = 0; fin = 0;
        done_last = 1'b0; prev_ce = 1'b0; prev_lb = 1'b0;
        for (int c = 0; c < 1200 && !fin; c++) begin
            @(negedge clk);
            idx++;
            trigger_channel_mask = 8'($urandom);
            inst_readout = (idx == overlap_at);
            if (!busy) begin
                fin = 1;
            end else begin
                busy_n++;
                done_last = done;
                if (done) dn_n++;
                if (last_bit) lb_n++;
                if (idx == 1 || select_reg != prev_sel) quiet = 0;
                if (quiet < int'(S) && clk_enable) viol++;
                quiet++;
                prev_sel = select_reg;
                if (clk_enable) begin
                    ce_n++;
                    run++;
                    if (!prev_ce) begin
                        seq.push_back(int'(select_reg));
                        if (first_ce < 0) first_ce = idx;
                    end
                end else if (prev_ce) begin
                    if (run != int'(B) || !prev_lb) bad_run++;
                    run = 0;
                end
                prev_ce = clk_enable;
                prev_lb = last_bit;
            end
        end
        inst_readout = 1'b0;
        chk("terminated", {31'b0, fin}, 1);
        chk("busy_cycles", busy_n, k * (S + B + 1) + 1);
        chk("clk_enable_cycles", ce_n, k * B);
        chk("last_bit_pulses", lb_n, k);
        chk("done_pulses", dn_n, 1);
        chk("done_in_last_busy", {31'b0, done_last}, 1);
        chk("settle_violations", viol, 0);
        chk("bad_shift_runs", bad_run, 0);
        chk("channel_count", seq.size(), k);
        for (int i = 0; i < k && i < seq.size(); i++) chk("channel_order", seq[i], exp_q[i]);
        if (k > 0) chk("first_clk_enable_cycle", first_ce, S + 1);
        @(negedge clk);
        chk("idle_after_done", {31'b0, busy}, 0);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("rst_select", {29'b0, select_reg}, 0);
        chk("rst_clk_enable", {31'b0, clk_enable}, 0);
        chk("rst_last_bit", {31'b0, last_bit}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        rst = 1'b0;

        do_readout(8'b0010_1001, -1);
        do_readout(8'h00, -1);
        do_readout(8'h80, -1);

        // Abort during the 10th shift cycle of channel 3.
        start_pulse(8'hFF);
        n = 0;
        for (int c = 0; c < 500 && n < 10; c++) begin
            @(negedge clk);
            if (clk_enable && select_reg == 3'd3) n++;
        end
        chk("abort_reached", n, 10);
        inst_rst = 1'b1;
        @(negedge clk);
        inst_rst = 1'b0;
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_clk_enable", {31'b0, clk_enable}, 0);
        chk("abort_last_bit", {31'b0, last_bit}, 0);
        chk("abort_done", {31'b0, done}, 0);
        chk("abort_select_held", {29'b0, select_reg}, 3);
        n = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done || busy) n++;
        end
        chk("abort_quiet_after", n, 0);
        do_readout(8'hFF, -1);

        do_readout(8'h5A, 30);

        // Simultaneous abort and request in IDLE.
        @(negedge clk);
        trigger_channel_mask = 8'hFF;
        inst_readout = 1'b1;
        inst_rst = 1'b1;
        @(negedge clk);
        inst_readout = 1'b0;
        inst_rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_wins_idle", {31'b0, busy}, 0);
        end

        for (int r = 0; r < 4; r++) begin
            do_readout(8'($urandom), (r % 2 == 0) ? int'($urandom_range(5, 60)) : -1);
        end

        // Asynchronous reset mid-shift, between edges.
        start_pulse(8'h04);
        for (int c = 0; c < 100 && !clk_enable; c++) @(negedge clk);
        chk("arst_reached_shift", {31'b0, clk_enable}, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_select", {29'b0, select_reg}, 0);
        chk("arst_clk_enable", {31'b0, clk_enable}, 0);
        chk("arst_last_bit", {31'b0, last_bit}, 0);
        chk("arst_busy", {31'b0, busy}, 0);
        chk("arst_done", {31'b0, done}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_stays_idle", {31'b0, busy}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
